regfile: RTL

- General-purpose register file of the GeMIPS core.
- Sits at the receiving end of the write-back interface: it consumes the WB stage's write-enable, address and data, and commits them on the rising clock edge.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- Emits a registered commit trace for difftest/trace comparison.

---
 rtl/gemips_defs.sv | 15 +
 rtl/regfile_rport.sv | 30 +++
 rtl/regfile.sv | 67 ++++++
 3 files changed

// File: rtl/gemips_defs.sv
// Shared GeMIPS core constants: datapath widths, register-file geometry and
// the enable/reset encodings used by the ID/EX/MEM/WB stages.
package gemips_defs;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;
endpackage

// File: rtl/regfile_rport.sv
// One combinational read port of the register file with same-cycle
// write-back bypass; reset, disable and $0 all force a zero result.
module regfile_rport
    import gemips_defs::*;
(
    input  logic              rst,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rdata
);
    always_comb begin
        rdata = '0;
        if (rst == RST_ENABLE) begin
            rdata = '0;
        end else if (ren == READ_DISABLE) begin
            rdata = '0;
        end else if (raddr == ZERO_REG) begin
            rdata = '0;
        end else if (we == WRITE_ENABLE && waddr == raddr) begin
            // WB result being committed this cycle is forwarded to ID
            rdata = wdata;
        end else begin
            rdata = mem_data;
        end
    end
endmodule

// File: rtl/regfile.sv
// GeMIPS general-purpose register file: WB-side commit, two bypassed read
// ports for ID, and a registered commit trace with a running commit count.
module regfile
    import gemips_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              trace_we,
    output logic [ADDR_W-1:0] trace_waddr,
    output logic [DATA_W-1:0] trace_wdata,
    output logic [31:0]       commit_cnt
);
    logic [DATA_W-1:0] mem [NREG];
    logic              commit;

    // $0 writes are dropped entirely: no storage, no trace, no count
    assign commit = (we == WRITE_ENABLE) && (waddr != ZERO_REG);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
            trace_we    <= 1'b0;
            trace_waddr <= '0;
            trace_wdata <= '0;
            commit_cnt  <= '0;
        end else begin
            trace_we <= commit;
            if (commit) begin
                mem[waddr]  <= wdata;
                trace_waddr <= waddr;
                trace_wdata <= wdata;
                commit_cnt  <= commit_cnt + 32'd1;
            end
        end
    end

    regfile_rport u_rport1 (
        .rst      (rst),
        .ren      (re1),
        .raddr    (raddr1),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .mem_data (mem[raddr1]),
        .rdata    (rdata1)
    );

    regfile_rport u_rport2 (
        .rst      (rst),
        .ren      (re2),
        .raddr    (raddr2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .mem_data (mem[raddr2]),
        .rdata    (rdata2)
    );
endmodule
